exp4_unidade_controle_rodadas: RTL and testbench

Parametrised control unit for the memory game, successor of the single-pass control unit. It runs a growing-sequence game: round r requires the player to enter plays for positions 0..r, and each play is checked against the datapath memory. It owns the position counter, the round counter and a play-timeout counter, and drives the datapath's play register and compare path. It sits between the datapath (memory, play register, comparator, button edge detector) and the board I/O.

---
 rtl/exp4_pkg.sv | 24 ++
 rtl/contador_timeout.sv | 30 +++
 rtl/exp4_unidade_controle_rodadas.sv | 117 +++++++++++
 tb/tb_exp4_unidade_controle_rodadas.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/exp4_pkg.sv
// Shared state encodings and default parameters for the round-based memory game control unit.
// State values double as the db_estado debug codes, so the debug output is a direct view of the register.
package exp4_pkg;

  localparam int ADDR_W_DEF     = 4;
  localparam int LAST_ROUND_DEF = 15;
  localparam int TIMEOUT_DEF    = 3000;

  localparam logic [3:0] DB_ILEGAL = 4'hF;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMO        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERROU      = 4'hE
  } estado_t;

endpackage

// File: rtl/contador_timeout.sv
// Play-window counter: counts while conta is high, clears on zera; fim flags count == M-1.
// Zero-latency fim decode from the count register; no backpressure.
module contador_timeout #(
  parameter int M = 3000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = $clog2(M);
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/exp4_unidade_controle_rodadas.sv
// Round-based memory game control unit: owns position/round counters and drives the play register.
// Moore FSM with registered control outputs; optional play timeout built under TIMEOUT_EN.
module exp4_unidade_controle_rodadas
  import exp4_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LAST_ROUND = LAST_ROUND_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              igual,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic              zeraR,
  output logic              registraR,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic [3:0]        db_estado
);

  localparam logic [ADDR_W-1:0] ULTIMA_RODADA = ADDR_W'(LAST_ROUND);

  estado_t state, nxt;
  logic    fim_tempo;
  logic    timeout_r;

`ifdef TIMEOUT_EN
  contador_timeout #(.M(TIMEOUT)) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (state != ESPERA),
    .conta (state == ESPERA),
    .fim   (fim_tempo)
  );
  assign timeout = timeout_r;
`else
  assign fim_tempo = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      INICIAL:        nxt = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     nxt = ESPERA;
      // A play arriving on the last window cycle still counts.
      ESPERA:         nxt = jogada ? REGISTRA : (fim_tempo ? FIM_TIMEOUT : ESPERA);
      REGISTRA:       nxt = COMPARACAO;
      COMPARACAO: begin
        if (!igual)                       nxt = FIM_ERROU;
        else if (endereco != rodada)      nxt = PROXIMO;
        else if (rodada == ULTIMA_RODADA) nxt = FIM_ACERTOU;
        else                              nxt = PROXIMA_RODADA;
      end
      PROXIMO:        nxt = ESPERA;
      PROXIMA_RODADA: nxt = ESPERA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                      nxt = iniciar ? PREPARACAO : state;
      default:        nxt = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INICIAL;
      endereco  <= '0;
      rodada    <= '0;
      zeraR     <= 1'b1;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        PREPARACAO: begin
          endereco <= '0;
          rodada   <= '0;
        end
        PROXIMO:        endereco <= endereco + 1'b1;
        PROXIMA_RODADA: begin
          endereco <= '0;
          rodada   <= rodada + 1'b1;
        end
        default: ;
      endcase
      // Outputs follow the state being entered so they line up with it.
      zeraR     <= (nxt == INICIAL) || (nxt == PREPARACAO) || (nxt == PROXIMA_RODADA);
      registraR <= (nxt == REGISTRA);
      pronto    <= (nxt == FIM_ACERTOU) || (nxt == FIM_ERROU) || (nxt == FIM_TIMEOUT);
      acertou   <= (nxt == FIM_ACERTOU);
      errou     <= (nxt == FIM_ERROU);
      timeout_r <= (nxt == FIM_TIMEOUT);
    end
  end

`ifndef TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = timeout_r;
`endif

  always_comb begin
    db_estado = DB_ILEGAL;
    case (state)
      INICIAL, PREPARACAO, ESPERA, REGISTRA, COMPARACAO, PROXIMO,
      PROXIMA_RODADA, FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: db_estado = state;
      default: db_estado = DB_ILEGAL;
    endcase
  end

endmodule

// File: tb/tb_exp4_unidade_controle_rodadas.sv
// Directed bench for the round-based control unit with LAST_ROUND=3, TIMEOUT=8.
module tb_exp4_unidade_controle_rodadas;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic [3:0] endereco;
  logic [3:0] rodada;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  int tests_run    = 0;
  int tests_failed = 0;

  exp4_unidade_controle_rodadas #(
    .ADDR_W     (4),
    .LAST_ROUND (3),
    .TIMEOUT    (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .endereco  (endereco),
    .rodada    (rodada),
    .zeraR     (zeraR),
    .registraR (registraR),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From espera: pulse jogada, answer with igual=ok, check the decision state.
  task automatic play(input logic ok, input logic [3:0] exp_code);
    jogada = 1'b1;
    tick();
    check("registra_db", db_estado, 4'h4);
    check("registraR", registraR, 1'b1);
    jogada = 1'b0;
    igual  = ok;
    tick();
    check("comparacao_db", db_estado, 4'h5);
    tick();
    check("decisao_db", db_estado, exp_code);
    igual = 1'b0;
    if (exp_code == 4'h6 || exp_code == 4'h7) begin
      tick();
      check("volta_espera", db_estado, 4'h3);
    end
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    tick();
    check("prep_db", db_estado, 4'h1);
    check("prep_zeraR", zeraR, 1'b1);
    iniciar = 1'b0;
    tick();
    check("espera_db", db_estado, 4'h3);
    check("inicio_endereco", endereco, 4'd0);
    check("inicio_rodada", rodada, 4'd0);
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0;
    tick();
    tick();
    check("rst_zeraR", zeraR, 1'b1);
    check("rst_db", db_estado, 4'h0);
    check("rst_pronto", pronto, 1'b0);
    check("rst_registraR", registraR, 1'b0);
    check("rst_flags", {acertou, errou, timeout}, 3'b000);
    check("rst_endereco", endereco, 4'd0);
    check("rst_rodada", rodada, 4'd0);
    reset = 1'b0;
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    check("idle_db", db_estado, 4'h0);

    // Full win: 10 correct plays.
    start_game();
    for (int r = 0; r <= 3; r++) begin
      for (int e = 0; e <= r; e++) begin
        check("pos_endereco", endereco, 32'(e));
        check("pos_rodada", rodada, 32'(r));
        play(1'b1, (e != r) ? 4'h6 : ((r == 3) ? 4'hA : 4'h7));
      end
    end
    check("win_pronto", pronto, 1'b1);
    check("win_acertou", acertou, 1'b1);
    check("win_errou_timeout", {errou, timeout}, 2'b00);
    check("win_rodada", rodada, 4'd3);
    check("win_zeraR", zeraR, 1'b0);
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    tick();
    check("win_hold", db_estado, 4'hA);
    check("win_hold_acertou", acertou, 1'b1);

    // Error in round 2 at position 1.
    start_game();
    play(1'b1, 4'h7);
    play(1'b1, 4'h6);
    play(1'b1, 4'h7);
    play(1'b1, 4'h6);
    check("err_pre_endereco", endereco, 4'd1);
    check("err_pre_rodada", rodada, 4'd2);
    play(1'b0, 4'hE);
    check("err_errou", errou, 1'b1);
    check("err_pronto", pronto, 1'b1);
    check("err_acertou", acertou, 1'b0);
    check("err_endereco", endereco, 4'd1);

    // Restart from fim_errou is a fresh game.
    start_game();
    play(1'b1, 4'h7);
    check("fresh_rodada", rodada, 4'd1);

`ifdef TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    check("to_before", db_estado, 4'h3);
    tick();
    check("to_db", db_estado, 4'hD);
    check("to_timeout", timeout, 1'b1);
    check("to_pronto", pronto, 1'b1);
`else
    for (int i = 0; i < 100; i++) tick();
    check("noto_db", db_estado, 4'h3);
    check("noto_timeout", timeout, 1'b0);
    play(1'b0, 4'hE);
`endif

    // jogada on the last window cycle wins over the timeout.
    start_game();
    for (int i = 0; i < 7; i++) tick();
    check("coinc_espera", db_estado, 4'h3);
    play(1'b1, 4'h7);
    check("coinc_timeout", timeout, 1'b0);

    // Reach comparacao in round 2, then reset asynchronously.
    play(1'b1, 4'h6);
    play(1'b1, 4'h7);
    check("mid_rodada", rodada, 4'd2);
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    igual  = 1'b1;
    tick();
    check("mid_comparacao", db_estado, 4'h5);
    #2;
    reset = 1'b1;
    #1;
    check("async_db", db_estado, 4'h0);
    check("async_endereco", endereco, 4'd0);
    check("async_rodada", rodada, 4'd0);
    check("async_zeraR", zeraR, 1'b1);
    igual = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("after_rst_db", db_estado, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
